// File: rtl/onchip_mem_arbiter_pkg.sv
// Shared definitions for the two-requester on-chip memory arbiter.
package onchip_mem_arbiter_pkg;
    localparam int ID_W = 1;
    localparam logic [1:0] GRANT_NONE = 2'b00;
endpackage

// File: rtl/onchip_mem_arbiter_rr_arb2.sv
// Two-way round-robin arbiter; on a tie the requester that did not win last time is granted.
module rr_arb2
    import onchip_mem_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] req,
    output logic [1:0] grant
);
    logic [ID_W-1:0] last_grant;

    always_comb begin
        grant = GRANT_NONE;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = (last_grant == ID_W'(1)) ? 2'b01 : 2'b10;
            default: grant = GRANT_NONE;
        endcase
    end

    // Reset value 1 hands the first tie to requester 0.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_grant <= ID_W'(1);
        end else if (grant[0]) begin
            last_grant <= ID_W'(0);
        end else if (grant[1]) begin
            last_grant <= ID_W'(1);
        end
    end
endmodule

// File: rtl/onchip_mem_arbiter.sv
// Shares one single-port memory between two Avalon-MM requesters with a round-robin grant
// and a tag pipeline that routes read data back to the requester that issued the read.
module onchip_mem_arbiter
    import onchip_mem_arbiter_pkg::*;
#(
    parameter int ADDR_W     = 3,
    parameter int DATA_W     = 32,
    parameter int BE_W       = DATA_W / 8,
    parameter int RD_LATENCY = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] r0_address,
    input  logic [BE_W-1:0]   r0_byteenable,
    input  logic              r0_read,
    input  logic              r0_write,
    input  logic [DATA_W-1:0] r0_writedata,
    output logic              r0_waitrequest,
    output logic [DATA_W-1:0] r0_readdata,
    output logic              r0_readdatavalid,
    input  logic [ADDR_W-1:0] r1_address,
    input  logic [BE_W-1:0]   r1_byteenable,
    input  logic              r1_read,
    input  logic              r1_write,
    input  logic [DATA_W-1:0] r1_writedata,
    output logic              r1_waitrequest,
    output logic [DATA_W-1:0] r1_readdata,
    output logic              r1_readdatavalid,
    output logic [ADDR_W-1:0] mem_address,
    output logic [BE_W-1:0]   mem_byteenable,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic [DATA_W-1:0] mem_writedata,
    input  logic [DATA_W-1:0] mem_readdata
);
    logic [1:0]      req;
    logic [1:0]      grant;
    logic [ID_W-1:0] gnt_id;
    logic            gnt_wr;
    logic            issue_rd;

    logic [RD_LATENCY-1:0] tag_valid;
    logic [ID_W-1:0]       tag_id [RD_LATENCY];

    // Masking requests with reset_n keeps the memory port quiet while reset is held.
    assign req = {r1_read | r1_write, r0_read | r0_write} & {2{reset_n}};

    rr_arb2 u_rr_arb2 (
        .clk     (clk),
        .reset_n (reset_n),
        .req     (req),
        .grant   (grant)
    );

    assign gnt_id = grant[1] ? ID_W'(1) : ID_W'(0);
    assign gnt_wr = grant[1] ? r1_write : r0_write;

    assign mem_chipselect = |grant;
    assign mem_write      = mem_chipselect & gnt_wr;
    assign mem_address    = grant[1] ? r1_address    : r0_address;
    assign mem_byteenable = grant[1] ? r1_byteenable : r0_byteenable;
    assign mem_writedata  = grant[1] ? r1_writedata  : r0_writedata;

    // Read+write together counts as a write, so only pure reads are tracked.
    assign issue_rd = mem_chipselect & ~gnt_wr;

    assign r0_waitrequest = ~reset_n | grant[1];
    assign r1_waitrequest = ~reset_n | grant[0];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tag_valid <= '0;
            for (int i = 0; i < RD_LATENCY; i++) begin
                tag_id[i] <= '0;
            end
        end else begin
            tag_valid[0] <= issue_rd;
            tag_id[0]    <= gnt_id;
            for (int i = 1; i < RD_LATENCY; i++) begin
                tag_valid[i] <= tag_valid[i-1];
                tag_id[i]    <= tag_id[i-1];
            end
        end
    end

    assign r0_readdatavalid = tag_valid[RD_LATENCY-1] & (tag_id[RD_LATENCY-1] == ID_W'(0));
    assign r1_readdatavalid = tag_valid[RD_LATENCY-1] & (tag_id[RD_LATENCY-1] == ID_W'(1));
    assign r0_readdata      = mem_readdata;
    assign r1_readdata      = mem_readdata;
endmodule
